polar_to_rect: RTL and testbench
================================

// Module: polar_to_rect
// PURPOSE
//  Converts a polar sample (abs_i, angle_i) into rectangular form (real_o, imag_o).
//  It is the inverse of the CalAbsAngle datapath and uses a fully pipelined
//  rotation-mode CORDIC.
//  - Accepts one sample per clk; no backpressure.
//  - Sits on the synthesis side of the chain, after the magnitude/phase
//    processing stages.
// PARAMETERS
//  ITER   14  number of CORDIC micro-rotation stages (8..16)
//  FRAC   10  extra fractional bits carried in the x/y datapath
//  OUT_W  9   width of real_o/imag_o, signed two's complement; 9 covers +/-255
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  abs_i    in   8      magnitude, unsigned
//  angle_i  in   16     phase, unsigned; 2^16 = full turn (0x4000 = 90 deg)
//  val_i    in   1      input sample valid
//  real_o   out  OUT_W  abs*cos(angle), signed
//  imag_o   out  OUT_W  abs*sin(angle), signed
//  val_o    out  1      output valid
//  sat_o    out  1      saturation flag; present only with POL2RECT_SAT_FLAG_EN
// BEHAVIOUR
//  Reset: rst_n low asynchronously clears all outputs, including sat_o, to 0.
//   It also clears the whole valid shift chain, so in-flight samples are discarded.
//   No val_o is produced for samples accepted before reset.
//  Latency: val_o rises exactly LAT = ITER+2 clk after the edge that samples val_i=1.
//   Throughput is 1 sample/clk. Gaps in val_i appear as gaps in val_o, with
//   order preserved.
//  Output hold: real_o/imag_o update only on cycles with val_o=1; otherwise they hold.
//  Stage 0 (registered): quadrant pre-rotation on angle_i[15:14].
//   - 00: x0=+g,   y0=0,    z0=angle_i[13:0]
//   - 01: x0=0,    y0=+g,   z0=angle_i-0x4000
//   - 10: x0=-g,   y0=0,    z0=angle_i-0x8000
//   - 11: x0=0,    y0=-g,   z0=angle_i-0xC000
//   - Residual z is signed 16-bit, range [0, 0x3FFF].
//   - Gain pre-compensation: g = (abs_i * 16'h4DBA) >> (15-FRAC), where 0x4DBA = 1/K*2^15.
//  Stages 1..ITER (each registered), stage i = 0..ITER-1:
//   - d = (z>=0) ? +1 : -1
//   - x' = x - d*(y>>>i)
//   - y' = y + d*(x>>>i)
//   - z' = z - d*atan_tab[i]
//   - atan_tab[i] = round(atan(2^-i) * 2^16/(2*pi)); e.g. [0]=0x2000, [1]=0x12E4, [2]=0x09FB.
//   - x/y width is 8+FRAC+2 signed, so no intermediate overflow is allowed.
//  Final stage (registered):
//   - Round half away from zero by dropping FRAC bits.
//   - Saturate to [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)]; the most negative code
//     is never emitted.
//  Accuracy: |real_o - abs*cos|, |imag_o - abs*sin| <= 1 LSB for all 2^24 inputs.
//  Boundaries:
//   - abs_i = 0 gives 0,0 at any angle.
//   - Angles 0x0000/0x4000/0x8000/0xC000 are exact (+/-abs on one axis, 0 on the other).
//   - angle wrap-around: 0xFFFF is treated as just below a full turn; no discontinuity.
//   - val_i=0 stages still shift, but their data is don't-care.
//   - rst_n released mid-stream: the first val_o follows the first val_i sampled
//     after release by LAT.
// CONFIGURATION
//  POL2RECT_SAT_FLAG_EN defined:
//   - Port sat_o exists. It is registered alongside val_o and is 1 when either
//     real or imag was clamped in the final stage.
//   - It reads 0 whenever val_o=0.
//  Not defined: port sat_o is absent; clamping is still performed silently.
// TESTING
//  1. abs_i=100, angle_i=0x0000, one val_i pulse -> 14+2=16 clk later val_o=1,
//     real_o=100, imag_o=0.
//  2. abs_i=100 at angles 0x4000 / 0x8000 / 0xC000 on consecutive clks ->
//     (0,100) (-100,0) (0,-100) on 3 consecutive val_o.
//  3. abs_i=200, angle_i=0x2000 -> real_o=141, imag_o=141 (+/-1);
//     abs_i=255, angle_i=0xFFFF -> real_o=255, imag_o=-1..0; sat_o=0 unless clamped.
//  4. 1024-sample back-to-back stream, addr-driven from input_abs/input_angle
//     hex files -> every val_o matches the golden real/imag files within 1 LSB;
//     stop on first mismatch, report the index.
//  5. Assert rst_n=0 for 1 clk while 5 samples are in flight -> all outputs 0
//     immediately (async), no stale val_o. Next sample appears exactly LAT after
//     its val_i.
//  6. val_i toggled 1,0,1,1,0 with abs_i=0 on the valid cycles -> val_o pattern
//     1,0,1,1,0 delayed by LAT, real_o=imag_o=0.

Source files
------------

// File: rtl/polar_to_rect.sv
// polar_to_rect: polar (magnitude, phase) to rectangular conversion using a
// fully pipelined rotation-mode CORDIC. One sample per clk, no backpressure.
// Latency from the edge that samples val_i=1 to val_o=1 is ITER+2 clk.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears outputs and valid chain
//   abs_i    8-bit unsigned magnitude
//   angle_i  16-bit unsigned phase, 2^16 = full turn
//   val_i    input sample valid
//   real_o   abs*cos(angle), signed OUT_W bits, holds between valid outputs
//   imag_o   abs*sin(angle), signed OUT_W bits, holds between valid outputs
//   val_o    output valid
//   sat_o    clamp indicator, only when POL2RECT_SAT_FLAG_EN is defined
//
// Build option: define POL2RECT_SAT_FLAG_EN to add the sat_o port. Without it
// clamping still happens, it is just not reported.
module polar_to_rect #(
  parameter int unsigned ITER  = 14,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned OUT_W = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              abs_i,
  input  logic [15:0]             angle_i,
  input  logic                    val_i,
  output logic signed [OUT_W-1:0] real_o,
  output logic signed [OUT_W-1:0] imag_o,
  output logic                    val_o
`ifdef POL2RECT_SAT_FLAG_EN
  ,
  output logic                    sat_o
`endif
);

  localparam int unsigned ABS_W = 8;
  localparam int unsigned ANG_W = 16;
  localparam int unsigned XW    = ABS_W + FRAC + 2;
  localparam int unsigned PW    = ABS_W + 16;
  localparam int unsigned RW    = XW - FRAC;

  // 1/K * 2^15, pre-scales the magnitude so the CORDIC gain cancels
  localparam logic [15:0] GAIN = 16'h4DBA;

  localparam logic signed [XW-1:0] RND_POS = XW'(2 ** (FRAC - 1));
  localparam logic signed [XW-1:0] RND_NEG = XW'(2 ** (FRAC - 1) - 1);
  localparam logic signed [RW-1:0] R_MAX   = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] R_MIN   = -R_MAX;

  // round(atan(2^-i) * 2^16 / (2*pi))
  function automatic logic [ANG_W-1:0] atan_lut(input int unsigned idx);
    case (idx)
      0:       return 16'h2000;
      1:       return 16'h12E4;
      2:       return 16'h09FB;
      3:       return 16'h0511;
      4:       return 16'h028B;
      5:       return 16'h0146;
      6:       return 16'h00A3;
      7:       return 16'h0051;
      8:       return 16'h0029;
      9:       return 16'h0014;
      10:      return 16'h000A;
      11:      return 16'h0005;
      12:      return 16'h0003;
      13:      return 16'h0001;
      14:      return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // round half away from zero while dropping FRAC bits
  function automatic logic signed [RW-1:0] rnd(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] adj;
    adj = v + (v[XW-1] ? RND_NEG : RND_POS);
    return RW'(adj >>> FRAC);
  endfunction

  // symmetric clamp; the most negative code is never produced
  function automatic logic signed [OUT_W-1:0] clip(input logic signed [RW-1:0] r);
    if (r > R_MAX)      return OUT_W'(R_MAX);
    else if (r < R_MIN) return OUT_W'(R_MIN);
    else                return OUT_W'(r);
  endfunction

  function automatic logic clamped(input logic signed [RW-1:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

  // input capture
  logic [ABS_W-1:0] abs_q;
  logic [ANG_W-1:0] ang_q;
  logic             vin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_q <= '0;
      ang_q <= '0;
      vin_q <= 1'b0;
    end else begin
      abs_q <= abs_i;
      ang_q <= angle_i;
      vin_q <= val_i;
    end
  end

  // CORDIC pipeline storage; index 0 is the pre-rotated stage
  logic signed [XW-1:0]    x_q [0:ITER];
  logic signed [XW-1:0]    y_q [0:ITER];
  logic signed [ANG_W-1:0] z_q [0:ITER-1];
  logic                    v_q [0:ITER];

  logic signed [XW-1:0] g_c;
  logic signed [XW-1:0] x0_c;
  logic signed [XW-1:0] y0_c;

  // gain-compensated magnitude and quadrant pre-rotation
  always_comb begin
    g_c  = XW'((PW'(abs_q) * PW'(GAIN)) >> (15 - FRAC));
    x0_c = '0;
    y0_c = '0;
    case (ang_q[15:14])
      2'b00:   x0_c = g_c;
      2'b01:   y0_c = g_c;
      2'b10:   x0_c = -g_c;
      default: y0_c = -g_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q[0] <= '0;
      y_q[0] <= '0;
      z_q[0] <= '0;
      v_q[0] <= 1'b0;
    end else begin
      x_q[0] <= x0_c;
      y_q[0] <= y0_c;
      z_q[0] <= {2'b00, ang_q[13:0]};
      v_q[0] <= vin_q;
    end
  end

  // micro-rotation stages; z is not needed after the last one
  for (genvar i = 0; i < ITER; i++) begin : g_rot
    localparam logic signed [ANG_W-1:0] ATAN = atan_lut(i);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q[i+1] <= '0;
        y_q[i+1] <= '0;
        v_q[i+1] <= 1'b0;
      end else begin
        v_q[i+1] <= v_q[i];
        if (!z_q[i][ANG_W-1]) begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
        end else begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
        end
      end
    end

    if (i < ITER - 1) begin : g_z
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          z_q[i+1] <= '0;
        end else if (!z_q[i][ANG_W-1]) begin
          z_q[i+1] <= z_q[i] - ATAN;
        end else begin
          z_q[i+1] <= z_q[i] + ATAN;
        end
      end
    end
  end

  logic signed [RW-1:0] rx_c;
  logic signed [RW-1:0] ry_c;

  always_comb begin
    rx_c = rnd(x_q[ITER]);
    ry_c = rnd(y_q[ITER]);
  end

  // output stage: data registers only load on valid so they hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      real_o <= '0;
      imag_o <= '0;
      val_o  <= 1'b0;
`ifdef POL2RECT_SAT_FLAG_EN
      sat_o  <= 1'b0;
`endif
    end else begin
      val_o <= v_q[ITER];
      if (v_q[ITER]) begin
        real_o <= clip(rx_c);
        imag_o <= clip(ry_c);
      end
`ifdef POL2RECT_SAT_FLAG_EN
      sat_o <= v_q[ITER] & (clamped(rx_c) | clamped(ry_c));
`endif
    end
  end

endmodule

// File: tb/tb_polar_to_rect.sv
// tb_polar_to_rect: scoreboard bench for polar_to_rect. The driver pushes the
// hand-computed expected result of each issued sample into a queue; the
// monitor pops on every val_o and also checks reset, output hold and latency.
module tb_polar_to_rect;

  localparam int unsigned ITER  = 14;
  localparam int unsigned OUT_W = 9;
  localparam int          LAT   = ITER + 2;

  logic                    clk     = 1'b0;
  logic                    rst_n   = 1'b1;
  logic [7:0]              abs_i   = '0;
  logic [15:0]             angle_i = '0;
  logic                    val_i   = 1'b0;
  logic signed [OUT_W-1:0] real_o;
  logic signed [OUT_W-1:0] imag_o;
  logic                    val_o;
`ifdef POL2RECT_SAT_FLAG_EN
  logic                    sat_o;
`endif

  polar_to_rect #(.ITER(ITER), .FRAC(10), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .abs_i   (abs_i),
    .angle_i (angle_i),
    .val_i   (val_i),
    .real_o  (real_o),
    .imag_o  (imag_o),
    .val_o   (val_o)
`ifdef POL2RECT_SAT_FLAG_EN
    ,
    .sat_o   (sat_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    int tol;
    int issue;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;
  int   last_re  = 0;
  int   last_im  = 0;
  int   last_tol = 0;

  task automatic chk(input string name, input int act, input int want, input int tol);
    int d;
    checks++;
    d = act - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (tol %0d) cycle %0d", name, act, want, tol, cyc);
    end
  endtask

  // one sample, sampled by the next posedge
  task automatic send(input logic [7:0] a, input logic [15:0] ang,
                      input int re, input int im, input int tol);
    exp_t e;
    @(negedge clk);
    abs_i   = a;
    angle_i = ang;
    val_i   = 1'b1;
    e.re    = re;
    e.im    = im;
    e.tol   = tol;
    e.issue = cyc;
    q.push_back(e);
  endtask

  // idle cycles carry junk data that must never reach the outputs
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      val_i   = 1'b0;
      abs_i   = 8'($urandom);
      angle_i = 16'($urandom);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * LAT && q.size() != 0; k++) idle(1);
  endtask

  // driver
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single sample at angle 0
    send(8'd100, 16'h0000, 100, 0, 0);
    idle(1);
    drain();

    // remaining axis angles back to back
    send(8'd100, 16'h4000, 0, 100, 0);
    send(8'd100, 16'h8000, -100, 0, 0);
    send(8'd100, 16'hC000, 0, -100, 0);
    idle(1);
    drain();

    // off-axis angles, wrap-around and small/zero magnitudes
    send(8'd200, 16'h2000, 141, 141, 1);
    send(8'd255, 16'hFFFF, 255, 0, 1);
    send(8'd50,  16'h1555, 43, 25, 1);
    send(8'd255, 16'h6000, -180, 180, 1);
    send(8'd128, 16'hA000, -91, -91, 1);
    send(8'd1,   16'h0000, 1, 0, 0);
    send(8'd255, 16'h4000, 0, 255, 0);
    send(8'd0,   16'h1234, 0, 0, 0);
    idle(1);
    drain();

    // valid pattern 1,0,1,1,0 with zero magnitude
    send(8'd0, 16'h3A5C, 0, 0, 0);
    idle(1);
    send(8'd0, 16'h9001, 0, 0, 0);
    send(8'd0, 16'hE7F3, 0, 0, 0);
    idle(1);
    drain();

    // reset while five samples are in flight
    for (int k = 0; k < 5; k++) send(8'd77, 16'(k * 16'h1000), 0, 0, 0);
    idle(1);
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    send(8'd100, 16'h8000, -100, 0, 0);
    idle(1);
    drain();

    done = 1'b1;
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("rst_val_o", int'(val_o), 0, 0);
        chk("rst_real_o", int'(real_o), 0, 0);
        chk("rst_imag_o", int'(imag_o), 0, 0);
`ifdef POL2RECT_SAT_FLAG_EN
        chk("rst_sat_o", int'(sat_o), 0, 0);
`endif
        q.delete();
        last_re  = 0;
        last_im  = 0;
        last_tol = 0;
      end else if (val_o) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_val_o: got val_o=1 with nothing outstanding, cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("real_o", int'(real_o), e.re, e.tol);
          chk("imag_o", int'(imag_o), e.im, e.tol);
          // the sampling edge itself advances cyc once
          chk("latency", cyc - e.issue, LAT + 1, 0);
`ifdef POL2RECT_SAT_FLAG_EN
          chk("sat_o", int'(sat_o), 0, 0);
`endif
          last_re  = e.re;
          last_im  = e.im;
          last_tol = e.tol;
        end
      end else begin
        chk("hold_real_o", int'(real_o), last_re, last_tol);
        chk("hold_imag_o", int'(imag_o), last_im, last_tol);
`ifdef POL2RECT_SAT_FLAG_EN
        chk("idle_sat_o", int'(sat_o), 0, 0);
`endif
      end
      if (done) begin
        chk("outstanding", q.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
